// File: rtl/neuro_seq_pkg.sv
// Shared types, default geometry and helper functions for the neuro frame sequencer.
package neuro_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_LOAD,
        ST_RUN,
        ST_VOTE
    } seq_state_e;

    localparam int DEF_IMG_W    = 128;
    localparam int DEF_IMG_H    = 128;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_PIX_W    = 8;
    localparam int DEF_OUT_W    = 13;
    localparam int DEF_RES_W    = 4;
    localparam int DEF_VOTE_N   = 3;
    localparam int DEF_CNT_W    = 32;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int norm_shift(input int out_w, input int pix_w);
        return out_w - pix_w - 1;
    endfunction

    localparam int DEF_PLANE  = DEF_IMG_W * DEF_IMG_H;
    localparam int DEF_PIX_AW = addr_width(DEF_PLANE);
    localparam int DEF_IMG_AW = addr_width(DEF_CHANNELS * DEF_PLANE);

endpackage

// File: rtl/neuro_frame_sequencer_if.sv
// Bus bundle between the sequencer, frame buffer, image memory and network.
interface neuro_frame_sequencer_if
    import neuro_seq_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int RES_W    = DEF_RES_W,
    parameter int CNT_W    = DEF_CNT_W
);
    localparam int PIX_AW = addr_width(IMG_W * IMG_H);
    localparam int IMG_AW = addr_width(CHANNELS * IMG_W * IMG_H);

    logic                        run;
    logic                        frame_ready;
    logic                        pix_re;
    logic [PIX_AW-1:0]           pix_addr;
    logic [CHANNELS*PIX_W-1:0]   pix_data;
    logic                        img_we;
    logic [IMG_AW-1:0]           img_addr;
    logic signed [OUT_W-1:0]     img_data;
    logic                        net_go;
    logic                        net_stop;
    logic [RES_W-1:0]            net_result;
    logic [RES_W-1:0]            result;
    logic                        result_valid;
    logic                        busy;
    logic [CNT_W-1:0]            latency;

    modport master (
        input  run, frame_ready, pix_data, net_stop, net_result,
        output pix_re, pix_addr, img_we, img_addr, img_data, net_go,
               result, result_valid, busy, latency
    );

    modport slave (
        output run, frame_ready, pix_data, net_stop, net_result,
        input  pix_re, pix_addr, img_we, img_addr, img_data, net_go,
               result, result_valid, busy, latency
    );

endinterface

// File: rtl/result_voter.sv
// Sliding-window majority voter: newest value until the window fills, then
// strict majority, holding the previous result when no value has one.
module result_voter #(
    parameter int RES_W  = 4,
    parameter int VOTE_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [RES_W-1:0] din,
    input  logic             clear,
    output logic [RES_W-1:0] result,
    output logic             valid
);
    localparam int FILL_W = $clog2(VOTE_N + 1);

    logic [RES_W-1:0]  hist   [0:VOTE_N-1];
    logic [RES_W-1:0]  window [0:VOTE_N-1];
    logic [FILL_W-1:0] fill;
    logic              maj_found;
    logic [RES_W-1:0]  maj_val;
    int                votes;

    // The window seen by a push is the incoming value plus the newest VOTE_N-1 entries.
    always_comb begin
        window[0] = din;
        for (int i = 1; i < VOTE_N; i++) begin
            window[i] = hist[i-1];
        end
        maj_found = 1'b0;
        maj_val   = din;
        votes     = 0;
        for (int i = 0; i < VOTE_N; i++) begin
            votes = 0;
            for (int j = 0; j < VOTE_N; j++) begin
                if (window[j] == window[i]) begin
                    votes = votes + 1;
                end
            end
            if (votes > VOTE_N / 2) begin
                maj_found = 1'b1;
                maj_val   = window[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOTE_N; i++) begin
                hist[i] <= '0;
            end
            fill   <= '0;
            result <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= push;
            if (clear) begin
                for (int i = 0; i < VOTE_N; i++) begin
                    hist[i] <= '0;
                end
                fill <= '0;
            end else if (push) begin
                for (int i = VOTE_N - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0] <= din;
                if (fill != FILL_W'(VOTE_N)) begin
                    fill <= fill + FILL_W'(1);
                end
                if (fill < FILL_W'(VOTE_N - 1)) begin
                    result <= din;
                end else if (maj_found) begin
                    result <= maj_val;
                end
            end
        end
    end

endmodule

// File: rtl/neuro_frame_sequencer.sv
// Per-frame inference sequencer: load/normalise frame, run network, vote on result.
// Optional latency counter is built when NEURO_SEQ_LATENCY_EN is defined.
module neuro_frame_sequencer
    import neuro_seq_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int RES_W    = DEF_RES_W,
    parameter int VOTE_N   = DEF_VOTE_N,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic                     clk,
    input logic                     rst_n,
    neuro_frame_sequencer_if.master bus
);
    localparam int PLANE  = IMG_W * IMG_H;
    localparam int PIX_AW = addr_width(PLANE);
    localparam int IMG_AW = addr_width(CHANNELS * PLANE);
    localparam int CH_W   = addr_width(CHANNELS);
    localparam int SHIFT  = norm_shift(OUT_W, PIX_W);
    localparam logic signed [OUT_W-1:0] PIX_MAX = OUT_W'((1 << PIX_W) - 1);

    seq_state_e              state, state_next;
    logic [PIX_AW-1:0]       rd_pix;
    logic [CH_W-1:0]         rd_ch;
    logic [CH_W-1:0]         wr_ch;
    logic                    rd_done;
    logic                    run_armed;
    logic                    img_we_q;
    logic [IMG_AW-1:0]       img_addr_q;
    logic                    pix_re;
    logic                    net_go;
    logic                    stop_hit;
    logic                    busy;
    logic [PIX_W-1:0]        wr_pix;
    logic signed [OUT_W-1:0] centered;
    logic signed [OUT_W-1:0] img_data_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (bus.run) state_next = ST_WAIT_FRAME;
            ST_WAIT_FRAME: begin
                if (bus.frame_ready) begin
                    state_next = ST_LOAD;
                end else if (!bus.run) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD:       if (rd_done) state_next = ST_RUN;
            ST_RUN:        if (stop_hit) state_next = ST_VOTE;
            ST_VOTE:       state_next = bus.run ? ST_WAIT_FRAME : ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // run_armed is low only in the first RUN cycle, which is where net_go fires.
    always_comb begin
        pix_re   = (state == ST_LOAD) && !rd_done;
        net_go   = (state == ST_RUN) && !run_armed;
        stop_hit = (state == ST_RUN) && run_armed && bus.net_stop;
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pix     <= '0;
            rd_ch      <= '0;
            rd_done    <= 1'b0;
            wr_ch      <= '0;
            img_we_q   <= 1'b0;
            img_addr_q <= '0;
            run_armed  <= 1'b0;
        end else begin
            run_armed <= (state == ST_RUN) && (state_next == ST_RUN);
            img_we_q  <= pix_re;
            if (pix_re) begin
                img_addr_q <= IMG_AW'(rd_ch) * IMG_AW'(PLANE) + IMG_AW'(rd_pix);
                wr_ch      <= rd_ch;
                if (rd_pix == PIX_AW'(PLANE - 1)) begin
                    rd_pix <= '0;
                    if (rd_ch == CH_W'(CHANNELS - 1)) begin
                        rd_ch   <= '0;
                        rd_done <= 1'b1;
                    end else begin
                        rd_ch <= rd_ch + CH_W'(1);
                    end
                end else begin
                    rd_pix <= rd_pix + PIX_AW'(1);
                end
            end else if (state != ST_LOAD) begin
                rd_done <= 1'b0;
            end
        end
    end

    // Read data arrives in the cycle the write is issued, so the sample is formed from it directly.
    always_comb begin
        wr_pix     = bus.pix_data[wr_ch*PIX_W +: PIX_W];
        centered   = $signed({{(OUT_W-PIX_W-1){1'b0}}, wr_pix, 1'b0}) - PIX_MAX;
        img_data_n = img_we_q ? (centered <<< SHIFT) : '0;
    end

`ifdef NEURO_SEQ_LATENCY_EN
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_q;

    // The net_go cycle is itself a RUN cycle, so the count restarts at 1 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            lat_q   <= '0;
        end else begin
            if (net_go) begin
                lat_cnt <= CNT_W'(1);
            end else if ((state == ST_RUN) && (lat_cnt != '1)) begin
                lat_cnt <= lat_cnt + CNT_W'(1);
            end
            if (stop_hit) begin
                lat_q <= lat_cnt;
            end
        end
    end

    assign bus.latency = lat_q;
`else
    assign bus.latency = {CNT_W{1'b0}};
`endif

    result_voter #(
        .RES_W  (RES_W),
        .VOTE_N (VOTE_N)
    ) u_voter (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (stop_hit),
        .din    (bus.net_result),
        .clear  ((state == ST_IDLE) && bus.run),
        .result (bus.result),
        .valid  (bus.result_valid)
    );

    assign bus.pix_re   = pix_re;
    assign bus.pix_addr = rd_pix;
    assign bus.img_we   = img_we_q;
    assign bus.img_addr = img_addr_q;
    assign bus.img_data = img_data_n;
    assign bus.net_go   = net_go;
    assign bus.busy     = busy;

endmodule
